// File: rtl/rep_umul_ctrl.sv
// rep_umul_ctrl: sequencer for a repeated-unary multiplier. Streams A as a front-loaded
// unary bitstream and counts ones on the multiplier output. Optional abort: REP_UMUL_CTRL_ABORT_EN.
module rep_umul_ctrl #(
   parameter int BITWIDTH = 8,
   parameter int MUL_LAT  = 1
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iA,
   input  logic [BITWIDTH-1:0] iB,
   output logic                oValid,
   input  logic                iReady,
   output logic [BITWIDTH-1:0] oProd,
   output logic                oLoadB,
   output logic [BITWIDTH-1:0] oB,
   output logic                oClr,
   output logic                oEn,
   output logic                oA,
   input  logic                iMult
`ifdef REP_UMUL_CTRL_ABORT_EN
   ,
   input  logic                iAbort
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, DRAIN, DONE} stateT;

   localparam logic [2:0] DRAIN_LAST = 3'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

   stateT               stateReg, stateNext;
   logic [BITWIDTH-1:0] aReg, bReg, prodReg, runCntReg;
   logic [2:0]          drainCntReg;
   logic [BITWIDTH:0]   onesCntReg, onesNext;
   logic                abortHit, abortClrReg, enOut, doneEntry;

`ifdef REP_UMUL_CTRL_ABORT_EN
   assign abortHit = iAbort && (stateReg inside {LOAD, CLEAR, RUN, DRAIN});
`else
   assign abortHit = 1'b0;
`endif

   always_comb begin
      stateNext = stateReg;
      oReady    = 1'b0;
      oLoadB    = 1'b0;
      oClr      = abortClrReg;
      oEn       = 1'b0;
      oA        = 1'b0;
      oValid    = 1'b0;
      case (stateReg)
         IDLE: begin
            oReady = 1'b1;
            if (iValid) stateNext = LOAD;
         end
         LOAD: begin
            oLoadB    = 1'b1;
            stateNext = CLEAR;
         end
         CLEAR: begin
            oClr      = 1'b1;
            stateNext = RUN;
         end
         RUN: begin
            oEn = 1'b1;
            oA  = (runCntReg < aReg);
            if (runCntReg == '1) stateNext = (MUL_LAT == 0) ? DONE : DRAIN;
         end
         DRAIN: begin
            if (drainCntReg == DRAIN_LAST) stateNext = DONE;
         end
         DONE: begin
            oValid = 1'b1;
            if (iReady) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (abortHit) stateNext = IDLE;
   end

   assign oB        = bReg;
   assign oProd     = prodReg;
   assign doneEntry = (stateNext == DONE) && (stateReg != DONE);

   // Delay oEn to line up with the multiplier's output bit for the same stream position.
   generate
      if (MUL_LAT == 0) begin : gNoPipe
         assign enOut = oEn;
      end else begin : gPipe
         logic [MUL_LAT-1:0] enPipeReg;
         always_ff @(posedge iClk or negedge iRstN) begin
            if (!iRstN) begin
               enPipeReg <= '0;
            end else if (abortHit) begin
               enPipeReg <= '0;
            end else begin
               enPipeReg[0] <= oEn;
               for (int i = 1; i < MUL_LAT; i++) enPipeReg[i] <= enPipeReg[i-1];
            end
         end
         assign enOut = enPipeReg[MUL_LAT-1];
      end
   endgenerate

   assign onesNext = onesCntReg + (BITWIDTH+1)'(enOut && iMult);

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         stateReg    <= IDLE;
         aReg        <= '0;
         bReg        <= '0;
         prodReg     <= '0;
         runCntReg   <= '0;
         drainCntReg <= '0;
         onesCntReg  <= '0;
         abortClrReg <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         abortClrReg <= abortHit;
         if (stateReg == IDLE && iValid) begin
            aReg <= iA;
            bReg <= iB;
         end
         runCntReg   <= (stateReg == RUN) ? runCntReg + BITWIDTH'(1) : '0;
         drainCntReg <= (stateReg == DRAIN) ? drainCntReg + 3'd1 : 3'd0;
         onesCntReg  <= (stateReg == CLEAR) ? '0 : onesNext;
         // The final sample lands on the same edge that enters DONE, so use onesNext.
         if (doneEntry) prodReg <= onesNext[BITWIDTH] ? '1 : onesNext[BITWIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_rep_umul_ctrl.sv
// Self-checking bench for rep_umul_ctrl: cycle-offset reference model plus literal checks.
module tb_rep_umul_ctrl;
   localparam int BW     = 8;
   localparam int LAT    = 1;
   localparam int RUNLEN = 1 << BW;
   localparam int DONEK  = RUNLEN + 2 + LAT;

   logic          iClk = 1'b0;
   logic          iRstN, iValid, iReady, iMult;
   logic [BW-1:0] iA, iB;
   logic          oReady, oValid, oLoadB, oClr, oEn, oA;
   logic [BW-1:0] oProd, oB;
`ifdef REP_UMUL_CTRL_ABORT_EN
   logic          iAbort;
`endif

   always #5 iClk = ~iClk;

   rep_umul_ctrl #(.BITWIDTH(BW), .MUL_LAT(LAT)) dut (
      .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
      .iA(iA), .iB(iB), .oValid(oValid), .iReady(iReady), .oProd(oProd),
      .oLoadB(oLoadB), .oB(oB), .oClr(oClr), .oEn(oEn), .oA(oA), .iMult(iMult)
`ifdef REP_UMUL_CTRL_ABORT_EN
      , .iAbort(iAbort)
`endif
   );

   // Reference model: tracks cycles since accept (mK) and derives every output from it.
   bit            mBusy, mAbortClr, mAb;
   int            mK, mCnt;
   logic [BW-1:0] mA, mB, mProd;

   always @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         mBusy = 0; mAbortClr = 0; mK = 0; mCnt = 0; mA = '0; mB = '0; mProd = '0;
      end else begin
         mAbortClr = 0;
         if (mBusy) begin
            if (mK >= 2 + LAT && mK <= RUNLEN + 1 + LAT && iMult) mCnt++;
            mAb = 0;
`ifdef REP_UMUL_CTRL_ABORT_EN
            mAb = iAbort && (mK < DONEK);
`endif
            if (mAb) begin
               mBusy = 0; mAbortClr = 1;
            end else if (mK >= DONEK) begin
               if (iReady) mBusy = 0;
            end else begin
               mK++;
               if (mK == DONEK) mProd = (mCnt >= RUNLEN) ? {BW{1'b1}} : BW'(mCnt);
            end
         end else if (iValid) begin
            mBusy = 1; mK = 0; mCnt = 0; mA = iA; mB = iB;
         end
      end
   end

   int   checks = 0, fails = 0, tn = 0;
   int   loadCnt, clrCnt, enCnt, aCnt, loadTn, validTn, multMode;
   logic lastOA;

   task automatic check(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic compareAll();
      logic        eReady, eValid, eLoad, eClr, eEn, eA;
      logic [21:0] got, exp;
      eReady = !mBusy;
      eLoad  = mBusy && mK == 0;
      eClr   = (mBusy && mK == 1) || mAbortClr;
      eEn    = mBusy && mK >= 2 && mK <= RUNLEN + 1;
      eA     = eEn && ((mK - 2) < int'(mA));
      eValid = mBusy && mK >= DONEK;
      got = {oReady, oValid, oLoadB, oClr, oEn, oA, oB, oProd};
      exp = {eReady, eValid, eLoad, eClr, eEn, eA, mB, mProd};
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL outputs at tick %0d {rdy,vld,ldB,clr,en,a,B,prod}: got %b_%h_%h required %b_%h_%h",
                  tn, got[21:16], got[15:8], got[7:0], exp[21:16], exp[15:8], exp[7:0]);
      end
   endtask

   // One cycle: compare on the falling edge, gather stats, then drive the multiplier stand-in.
   task automatic tick();
      @(negedge iClk);
      #1;
      tn++;
      compareAll();
      if (oLoadB) begin loadCnt++; loadTn = tn; end
      if (oClr) clrCnt++;
      if (oEn) enCnt++;
      if (oA) aCnt++;
      if (oValid && validTn < 0) validTn = tn;
      case (multMode)
         0:       iMult = lastOA;
         1:       iMult = 1'b1;
         2:       iMult = 1'b0;
         default: iMult = 1'($urandom_range(0, 1));
      endcase
      lastOA = oA;
   endtask

   task automatic clrStats();
      loadCnt = 0; clrCnt = 0; enCnt = 0; aCnt = 0; loadTn = -1; validTn = -1;
   endtask

   task automatic startJob(int a, int b, int mode);
      clrStats();
      multMode = mode;
      iA = BW'(a); iB = BW'(b); iValid = 1'b1;
      for (int i = 0; i < 600 && !oLoadB; i++) tick();
      check("accept", oLoadB, 1);
      iValid = 1'b0;
   endtask

   task automatic waitValid();
      for (int i = 0; i < 400 && !oValid; i++) tick();
      check("oValid timeout", oValid, 1);
   endtask

   task automatic finishJob(int delay);
      for (int i = 0; i < delay; i++) tick();
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
      check("handshake drops oValid", oValid, 0);
   endtask

   initial begin
      iRstN = 1'b0; iValid = 1'b0; iReady = 1'b0; iMult = 1'b0; iA = '0; iB = '0;
`ifdef REP_UMUL_CTRL_ABORT_EN
      iAbort = 1'b0;
`endif
      multMode = 0; lastOA = 1'b0;
      clrStats();
      for (int i = 0; i < 3; i++) tick();
      check("reset oReady", oReady, 1);
      iRstN = 1'b1;
      tick();

      // Identity multiplier, A=100 B=157
      startJob(100, 157, 0);
      check("oB at load", oB, 157);
      waitValid();
      check("loadB cycles", loadCnt, 1);
      check("clr cycles", clrCnt, 1);
      check("en cycles", enCnt, 256);
      check("oA ones", aCnt, 100);
      check("latency", validTn - loadTn, 259);
      check("identity prod", oProd, 100);
      finishJob(0);

      // Saturation, zero, A=0
      startJob(50, 9, 1);
      waitValid();
      check("tied1 prod", oProd, 255);
      finishJob(2);
      startJob(200, 9, 2);
      waitValid();
      check("tied0 prod", oProd, 0);
      finishJob(1);
      startJob(0, 9, 0);
      waitValid();
      check("A=0 oA ones", aCnt, 0);
      check("A=0 prod", oProd, 0);
      finishJob(0);

      // Backpressure with a second request held during the stall
      startJob(77, 157, 0);
      waitValid();
      iValid = 1'b1; iA = 8'd33; iB = 8'd44;
      for (int i = 0; i < 50; i++) tick();
      check("stall oValid", oValid, 1);
      check("stall oReady", oReady, 0);
      check("stall oProd", oProd, 77);
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
      check("idle after handshake", oReady, 1);
      clrStats();
      tick();
      check("second accept", oLoadB, 1);
      iValid = 1'b0;
      check("second oB", oB, 44);
      waitValid();
      check("second prod", oProd, 33);
      finishJob(0);

      // Operand change after accept
      startJob(100, 157, 0);
      iA = 8'd7; iB = 8'd3;
      waitValid();
      check("held oB", oB, 157);
      check("held A ones", aCnt, 100);
      check("held prod", oProd, 100);
      finishJob(0);

      // Asynchronous reset at run cycle 120
      startJob(100, 157, 0);
      for (int i = 0; i < 122; i++) tick();
      check("mid-run oEn", oEn, 1);
      iRstN = 1'b0;
      #1;
      compareAll();
      check("reset oReady", oReady, 1);
      check("reset oEn", oEn, 0);
      check("reset oB", oB, 0);
      for (int i = 0; i < 3; i++) tick();
      iRstN = 1'b1;
      tick();
      check("post-reset oReady", oReady, 1);
      startJob(10, 5, 0);
      waitValid();
      check("post-reset prod", oProd, 10);
      finishJob(0);

`ifdef REP_UMUL_CTRL_ABORT_EN
      // Abort at run cycle 40
      startJob(60, 9, 0);
      for (int i = 0; i < 42; i++) tick();
      iAbort = 1'b1;
      tick();
      iAbort = 1'b0;
      check("abort oClr", oClr, 1);
      check("abort oReady", oReady, 1);
      check("abort oEn", oEn, 0);
      tick();
      check("abort oClr pulse", oClr, 0);
      for (int i = 0; i < 300; i++) tick();
      check("abort no oValid", int'(validTn < 0), 1);
      startJob(25, 6, 0);
      waitValid();
      check("post-abort prod", oProd, 25);
      finishJob(0);
`endif

      // Randomized jobs; the first pins A=255 with the identity multiplier
      for (int j = 0; j < 6; j++) begin
         int a, mode;
         a    = (j == 0) ? 255 : (j == 1) ? 1 : int'($urandom_range(0, 255));
         mode = (j == 0) ? 0 : int'($urandom_range(0, 3));
         startJob(a, int'($urandom_range(0, 255)), mode);
         for (int i = 0; i < 100; i++) begin
            iValid = 1'($urandom_range(0, 1));
            iA = BW'($urandom); iB = BW'($urandom);
            tick();
         end
         iValid = 1'b0;
         waitValid();
         if (j == 0) begin
            check("A=255 oA ones", aCnt, 255);
            check("A=255 prod", oProd, 255);
         end
         finishJob(int'($urandom_range(0, 5)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
